async_input_debounce: RTL and testbench
=======================================

ASYNC_INPUT_DEBOUNCE -- requirements
Module: async_input_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive equal samples needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter HOLD_CNT, default 1000: cycles of accepted-high level before the hold pulse fires; legal range 1..2^24-1.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port d, input, 1: level already synchronized to clk by the upstream bit synchronizer; no metastability hardening inside this block.
REQ-006 SHALL have port q, output, 1: debounced level.
REQ-007 SHALL have port rise, output, 1: one-cycle pulse when q goes 0->1.
REQ-008 SHALL have port fall, output, 1: one-cycle pulse when q goes 1->0.
REQ-009 SHALL have port hold, output, 1: one-cycle pulse after q has been 1 for HOLD_CNT cycles.
REQ-010 SHALL register all outputs; no combinational path from d to any output.

Function
REQ-011 SHALL implement four states: S_LOW, S_RISING, S_HIGH, S_FALLING.
REQ-012 S_LOW: q=0; d=1 sampled -> S_RISING, debounce counter loaded with 1; d=0 -> stay.
REQ-013 S_RISING: d=0 -> S_LOW, counter cleared, no output change; d=1 -> counter+1.
REQ-014 SHALL leave S_RISING for S_HIGH on the edge where d has been sampled 1 on DEBOUNCE_CNT consecutive edges; on that same edge q<=1, rise<=1.
REQ-015 S_HIGH: d=0 sampled -> S_FALLING, counter loaded with 1; d=1 -> stay.
REQ-016 S_FALLING: d=1 -> S_HIGH, counter cleared, no output change, hold counter not reset; d=0 -> counter+1.
REQ-017 SHALL leave S_FALLING for S_LOW on the edge where d has been sampled 0 on DEBOUNCE_CNT consecutive edges; on that edge q<=0, fall<=1.
REQ-018 Latency: rise/fall asserted exactly DEBOUNCE_CNT edges after the first sample of the new level (first sample = edge 1, pulse visible after edge DEBOUNCE_CNT).
REQ-019 rise, fall, hold SHALL each be high for exactly one cycle per event; rise and fall never high in the same cycle.
REQ-020 Hold counter SHALL clear on the edge q rises, increment each cycle q=1, and assert hold on the edge it reaches HOLD_CNT.
REQ-021 Hold counter SHALL saturate after firing: at most one hold pulse per accepted high period.
REQ-022 Hold counter SHALL keep counting while in S_FALLING (q still 1); it clears when q falls.
REQ-023 If q falls on the same edge the hold count would complete, fall SHALL assert and hold SHALL NOT.
REQ-024 Debounce counter width SHALL be $clog2(DEBOUNCE_CNT+1); hold counter width $clog2(HOLD_CNT+1); no wrap-around in either.
REQ-025 Any glitch shorter than DEBOUNCE_CNT cycles SHALL produce no change on any output.

Reset
REQ-026 While rst_n=0: state S_LOW, both counters 0, q=0, rise=0, fall=0, hold=0.
REQ-027 Reset assertion SHALL take effect asynchronously; deassertion SHALL be sampled on clk (caller supplies synchronized deassertion).
REQ-028 Reset mid-debounce or mid-hold SHALL abort the operation with no pulse; if d=1 after reset, rise fires DEBOUNCE_CNT edges after the first sampled d=1.

Verification (DEBOUNCE_CNT=4, HOLD_CNT=10)
REQ-029 d 0->1, held 20 cycles -> rise one cycle after edge 4, q=1 from edge 4, hold one cycle after edge 14, no second hold.
REQ-030 d pulses 1 for 3 cycles, 0 for 2, repeated 5 times -> q, rise, fall, hold stay 0 throughout.
REQ-031 q=1 stable, d drops to 0 for 3 cycles then returns 1 -> q stays 1, no fall, hold still fires on schedule.
REQ-032 q=1 stable, d 1->0 held -> fall one cycle after 4th zero sample, q=0, hold counter cleared (next press needs full 10 cycles).
REQ-033 d=1, rst_n pulsed low at edge 2 of debounce -> outputs 0 immediately; rise 4 edges after reset release.
REQ-034 Random d with glitch widths 1..8 for 10k cycles vs reference model -> exact cycle match on q, rise, fall, hold.

Source files
------------

// File: rtl/async_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : async_input_debounce
//  Description : Debounces a clk-synchronous level input. A level change is
//                accepted after DEBOUNCE_CNT consecutive equal samples.
//                Produces the debounced level, rise/fall pulses, and a single
//                hold pulse once the level has been high for HOLD_CNT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module async_input_debounce #(
   parameter int DEBOUNCE_CNT = 4,
   parameter int HOLD_CNT     = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall,
   output logic hold
);

   localparam int c_db_w   = $clog2(DEBOUNCE_CNT + 1);
   localparam int c_hold_w = $clog2(HOLD_CNT + 1);

   localparam logic [c_db_w-1:0]   c_db_one    = c_db_w'(1);
   localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DEBOUNCE_CNT - 1);
   localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CNT - 1);
   localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(HOLD_CNT);

   typedef enum logic [1:0] {
      S_LOW     = 2'd0,
      S_RISING  = 2'd1,
      S_HIGH    = 2'd2,
      S_FALLING = 2'd3
   } state_t;

   state_t              r_state;
   logic [c_db_w-1:0]   r_db_cnt;
   logic [c_hold_w-1:0] r_hold_cnt;
   logic                r_q;
   logic                r_rise;
   logic                r_fall;
   logic                r_hold;

   // The debounce run completes on this edge: the counter already holds
   // DEBOUNCE_CNT-1 matching samples and the current sample is one more.
   logic w_accept_high;
   logic w_accept_low;

   assign w_accept_high = (r_state == S_RISING)  &&  d && (r_db_cnt == c_db_last);
   assign w_accept_low  = (r_state == S_FALLING) && !d && (r_db_cnt == c_db_last);

   // Debounce state machine: tracks candidate level changes and drives q/rise/fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_LOW;
         r_db_cnt <= '0;
         r_q      <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         case (r_state)
            S_LOW: begin
               if (d) begin
                  r_state  <= S_RISING;
                  r_db_cnt <= c_db_one;
               end
            end
            S_RISING: begin
               if (!d) begin
                  // Glitch: abandon the candidate rise silently.
                  r_state  <= S_LOW;
                  r_db_cnt <= '0;
               end else if (w_accept_high) begin
                  r_state  <= S_HIGH;
                  r_db_cnt <= '0;
                  r_q      <= 1'b1;
                  r_rise   <= 1'b1;
               end else begin
                  r_db_cnt <= r_db_cnt + c_db_one;
               end
            end
            S_HIGH: begin
               if (!d) begin
                  r_state  <= S_FALLING;
                  r_db_cnt <= c_db_one;
               end
            end
            S_FALLING: begin
               if (d) begin
                  // Glitch: q never dropped, so the hold timer keeps running.
                  r_state  <= S_HIGH;
                  r_db_cnt <= '0;
               end else if (w_accept_low) begin
                  r_state  <= S_LOW;
                  r_db_cnt <= '0;
                  r_q      <= 1'b0;
                  r_fall   <= 1'b1;
               end else begin
                  r_db_cnt <= r_db_cnt + c_db_one;
               end
            end
            default: begin
               r_state  <= S_LOW;
               r_db_cnt <= '0;
               r_q      <= 1'b0;
            end
         endcase
      end
   end

   // Hold timer: counts accepted-high cycles, fires once, saturates, and is
   // cleared on both q transitions so a fall on the completing edge wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_cnt <= '0;
         r_hold     <= 1'b0;
      end else begin
         r_hold <= 1'b0;
         if (w_accept_high || w_accept_low) begin
            r_hold_cnt <= '0;
         end else if (r_q && (r_hold_cnt != c_hold_max)) begin
            r_hold_cnt <= r_hold_cnt + c_hold_one;
            r_hold     <= (r_hold_cnt == c_hold_last);
         end
      end
   end

   assign q    = r_q;
   assign rise = r_rise;
   assign fall = r_fall;
   assign hold = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_async_input_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_async_input_debounce
//  Description : Self-checking bench for async_input_debounce. A sample-history
//                reference model predicts q/rise/fall/hold every cycle; directed
//                segments also check event timing against fixed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_async_input_debounce;

   localparam int DB = 4;
   localparam int HC = 10;

   logic clk = 1'b0;
   logic rst_n;
   logic d;
   logic q, rise, fall, hold;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit m_q, m_rise, m_fall, m_hold;
   int m_edge;
   int m_rise_edge;
   bit hist[$];

   // observation of DUT events within a directed scenario
   int obs_i, rise_at, fall_at, hold_at, n_rise, n_fall, n_hold, n_qhigh;

   async_input_debounce #(.DEBOUNCE_CNT(DB), .HOLD_CNT(HC)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (d),
      .q    (q),
      .rise (rise),
      .fall (fall),
      .hold (hold)
   );

   always #5 clk = ~clk;

   task automatic check_bit(string tag, logic obs, logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_int(string tag, int obs, int exp);
      total++;
      assert (obs == exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q = 0; m_rise = 0; m_fall = 0; m_hold = 0;
      m_edge = 0;
      m_rise_edge = -1000000;
      hist.delete();
   endtask

   // A change is accepted when the last DB samples since the previous change
   // all differ from the current level; hold fires HC edges after the rise edge.
   task automatic model_edge(bit ds);
      bit all_diff;
      m_edge++;
      m_rise = 0; m_fall = 0; m_hold = 0;
      hist.push_back(ds);
      if (hist.size() > DB) void'(hist.pop_front());
      all_diff = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] == m_q) all_diff = 0;
      if (all_diff) begin
         m_q = !m_q;
         hist.delete();
         if (m_q) begin
            m_rise = 1;
            m_rise_edge = m_edge;
         end else begin
            m_fall = 1;
         end
      end else if (m_q && (m_edge == m_rise_edge + HC)) begin
         m_hold = 1;
      end
   endtask

   task automatic check_outputs();
      check_bit("q",    q,    m_q);
      check_bit("rise", rise, m_rise);
      check_bit("fall", fall, m_fall);
      check_bit("hold", hold, m_hold);
      check_bit("rise_fall_exclusive", rise & fall, 1'b0);
   endtask

   task automatic clear_obs();
      obs_i = 0; rise_at = -1; fall_at = -1; hold_at = -1;
      n_rise = 0; n_fall = 0; n_hold = 0; n_qhigh = 0;
   endtask

   task automatic step(bit dv);
      d = dv;
      @(posedge clk);
      model_edge(dv);
      #1;
      check_outputs();
      obs_i++;
      if (rise && rise_at < 0) rise_at = obs_i;
      if (fall && fall_at < 0) fall_at = obs_i;
      if (hold && hold_at < 0) hold_at = obs_i;
      n_rise  += int'(rise);
      n_fall  += int'(fall);
      n_hold  += int'(hold);
      n_qhigh += int'(q);
   endtask

   task automatic seg(bit dv, int n);
      for (int i = 0; i < n; i++) step(dv);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
   endtask

   initial begin
      bit v;
      int w;
      d     = 1'b0;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;
      seg(0, 3);

      // press held 20 cycles: rise after edge 4, one hold after edge 14
      clear_obs();
      seg(1, 20);
      check_int("press_rise_at", rise_at, 4);
      check_int("press_hold_at", hold_at, 14);
      check_int("press_hold_count", n_hold, 1);
      seg(0, 6);

      // short bursts never accepted
      clear_obs();
      for (int r = 0; r < 5; r++) begin
         seg(1, 3);
         seg(0, 2);
      end
      check_int("glitch_events", n_rise + n_fall + n_hold + n_qhigh, 0);

      // short low glitch while high: no fall, hold still on schedule
      clear_obs();
      seg(1, 7);
      seg(0, 3);
      seg(1, 10);
      check_int("lowglitch_fall_count", n_fall, 0);
      check_int("lowglitch_hold_at", hold_at, 14);
      check_bit("lowglitch_q_end", q, 1'b1);

      // release: fall after the 4th zero, then hold timer starts afresh
      clear_obs();
      seg(0, 6);
      check_int("release_fall_at", fall_at, 4);
      check_bit("release_q_end", q, 1'b0);
      clear_obs();
      seg(1, 20);
      check_int("repress_rise_at", rise_at, 4);
      check_int("repress_hold_at", hold_at, 14);
      seg(0, 6);

      // fall completes on the same edge the hold count would: fall only
      clear_obs();
      seg(1, 10);
      seg(0, 6);
      check_int("coincide_fall_at", fall_at, 14);
      check_int("coincide_hold_count", n_hold, 0);

      // reset in the middle of a debounce run, d stays high
      clear_obs();
      seg(1, 2);
      async_reset();
      clear_obs();
      seg(1, 8);
      check_int("postreset_rise_at", rise_at, 4);
      seg(0, 6);

      // reset while high and mid-hold: no pulse, everything aborted
      seg(1, 8);
      async_reset();
      clear_obs();
      seg(0, 4);
      check_int("midhold_abort_events", n_rise + n_fall + n_hold + n_qhigh, 0);

      // random glitch widths 1..8 against the model, with occasional resets
      v = 1'b0;
      for (int c = 0; c < 10000; c += w) begin
         w = int'($urandom_range(1, 8));
         v = !v;
         seg(v, w);
         if ($urandom_range(0, 199) == 0) async_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
